// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store path and an
// external burst requester. Define DMEM_ARB_RR_EN for round-robin ties instead of CPU priority.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic                  ext_last,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t        state_r;
  logic [BW-1:0] beat_cnt_r;
  logic          cpu_gnt_s;
  logic          ext_gnt_s;
  logic          unused_rdata_s;

`ifdef DMEM_ARB_RR_EN
  logic          last_owner_r;   // 1: EXT owned the port last
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_cnt_r;
`endif

  // Read data goes straight to both requesters; each one qualifies it with its own rvalid.
  assign unused_rdata_s = ^mem_rdata;

  // Grant decision from state, counters and current requests.
  always_comb begin
    cpu_gnt_s = 1'b0;
    ext_gnt_s = 1'b0;
    case (state_r)
      ARB: begin
`ifdef DMEM_ARB_RR_EN
        ext_gnt_s = ext_req & (~cpu_req | ~last_owner_r);
`else
        ext_gnt_s = ext_req & (~cpu_req | (starve_cnt_r == STARVE_LIM));
`endif
        cpu_gnt_s = cpu_req & ~ext_gnt_s;
      end
      BURST: begin
        ext_gnt_s = ext_req;
      end
      default: begin
        cpu_gnt_s = 1'b0;
        ext_gnt_s = 1'b0;
      end
    endcase
  end

  // Memory port mux; the port is parked at zero when nobody is granted.
  always_comb begin
    mem_en = cpu_gnt_s | ext_gnt_s;
    if (cpu_gnt_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt_s) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  assign cpu_gnt   = cpu_gnt_s;
  assign ext_gnt   = ext_gnt_s;
  assign cpu_stall = cpu_req & ~cpu_gnt_s;

  // Arbitration FSM, burst beat counter and registered read-valid flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ARB;
      beat_cnt_r <= {BW{1'b0}};
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt_s & ~cpu_we;
      ext_rvalid <= ext_gnt_s & ~ext_we;
      case (state_r)
        ARB: begin
          if (ext_gnt_s && !ext_last && (BURST_MAX > 1)) begin
            state_r    <= BURST;
            beat_cnt_r <= BW'(1);
          end else begin
            state_r    <= ARB;
            beat_cnt_r <= {BW{1'b0}};
          end
        end
        BURST: begin
          // A dropped request abandons the burst without a grant that cycle.
          if (!ext_req || ext_last || (beat_cnt_r == BEAT_LAST)) begin
            state_r    <= ARB;
            beat_cnt_r <= {BW{1'b0}};
          end else begin
            state_r    <= BURST;
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r    <= ARB;
          beat_cnt_r <= {BW{1'b0}};
        end
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin owner history; reset to EXT so the CPU takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= 1'b1;
    end else if (cpu_gnt_s) begin
      last_owner_r <= 1'b0;
    end else if (ext_gnt_s) begin
      last_owner_r <= 1'b1;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Counts cycles EXT has waited; saturates at the preemption threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (ext_gnt_s) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (ext_req && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected port state is queued as each cycle is driven
// and popped at the falling edge of that cycle for comparison.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        ext_req, ext_we, ext_last, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_last(ext_last), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ctl = {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}
  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] addr;
    logic [63:0] wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic prev_cr = 1'b0;
  logic prev_er = 1'b0;

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic ereq, input logic ewe, input logic elast,
                       input logic [31:0] eaddr, input logic xcg, input logic xeg);
    exp_t x;
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = {~caddr, caddr};
    ext_req = ereq; ext_we = ewe; ext_last = elast; ext_addr = eaddr;
    ext_wdata = {eaddr, ~eaddr};
    x.ctl  = {xcg, xeg, creq & ~xcg, xcg | xeg,
              xcg ? cwe : (xeg ? ewe : 1'b0), prev_cr, prev_er};
    x.addr = xcg ? caddr : (xeg ? eaddr : 32'h0);
    x.wd   = xcg ? {~caddr, caddr} : (xeg ? {eaddr, ~eaddr} : 64'h0);
    prev_cr = xcg & ~cwe;
    prev_er = xeg & ~ewe;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 64'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_last = 1'b0; ext_addr = 32'h0; ext_wdata = 64'h0;
    mem_rdata = 64'h0123_4567_89ab_cdef;
    #12;
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid, mem_addr} !== 39'h0) begin
      errors++;
      $display("FAIL reset_idle: got ctl=%b addr=%h, want all zero",
               {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, mem_addr);
    end
    cpu_req = 1'b1; cpu_addr = 32'h20;
    #1;
    checks++;
    if ({cpu_gnt, ext_gnt, mem_en, cpu_rvalid} !== 4'b1010 || mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL reset_comb_grant: got gnt/egnt/en/rv=%b addr=%h, want 1010 addr=00000020",
               {cpu_gnt, ext_gnt, mem_en, cpu_rvalid}, mem_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid_held: got %b want 0", cpu_rvalid);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prev_cr = 1'b0; prev_er = 1'b0;
  endtask

  task automatic test_rr();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b1, 1'b0, 32'h500, 1'b1, 1'b1, 1'b1, 32'h600, (i % 2) == 0, (i % 2) == 1);
      else       drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL rr_ctl cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL rr_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        1: drive(1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        2: drive(1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        3: drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 1'b1);
        default: drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 3;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL single_ctl cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL single_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
      if (mem_wdata !== e.wd) begin
        errors++;
        $display("FAIL single_wdata cyc %0d: got %h want %h", i, mem_wdata, e.wd);
      end
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, !(i == 4 || i == 9), i == 4 || i == 9);
      else        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 3;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL starve_ctl cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL starve_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
      if (mem_wdata !== e.wd) begin
        errors++;
        $display("FAIL starve_wdata cyc %0d: got %h want %h", i, mem_wdata, e.wd);
      end
    end
  endtask

  task automatic test_burst3();
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 1, 2, 3: drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0);
        4: drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 1'b1);
        5: drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h408, 1'b0, 1'b1);
        6: drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h410, 1'b0, 1'b1);
        7: drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        default: drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL burst3_ctl cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL burst3_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
    end
  endtask

  task automatic test_burst_cap();
    for (int i = 0; i < 11; i++) begin
      case (i)
        0: drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h700, 1'b0, 1'b1);
        1, 2, 3, 4, 5, 6, 7:
           drive(1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 1'b0, 32'h700 + 32'(8 * i), 1'b0, 1'b1);
        8: drive(1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 1'b0, 32'h740, 1'b1, 1'b0);
        9: drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h740, 1'b0, 1'b1);
        default: drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL burst_cap_ctl cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL burst_cap_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
    end
  endtask

  task automatic test_reset_burst();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h900, 1'b0, 1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
      errors++;
      $display("FAIL rstb_beat1 got %b want %b",
               {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
    end
    drive(1'b1, 1'b0, 32'hA00, 1'b1, 1'b0, 1'b0, 32'h908, 1'b0, 1'b1);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
      errors++;
      $display("FAIL rstb_beat2 got %b want %b",
               {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, ext_gnt, ext_rvalid} !== 3'b100 || mem_addr !== 32'hA00) begin
      errors++;
      $display("FAIL rstb_async got cgnt/egnt/erv=%b addr=%h want 100 addr=00000a00",
               {cpu_gnt, ext_gnt, ext_rvalid}, mem_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rstb_held got rvalids=%b want 00", {cpu_rvalid, ext_rvalid});
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prev_cr = 1'b0; prev_er = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b1, 1'b0, 32'hB00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      else        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid} !== e.ctl) begin
        errors++;
        $display("FAIL rstb_after cyc %0d: got %b want %b", i,
                 {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we, cpu_rvalid, ext_rvalid}, e.ctl);
      end
      if (mem_addr !== e.addr) begin
        errors++;
        $display("FAIL rstb_after_addr cyc %0d: got %h want %h", i, mem_addr, e.addr);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef DMEM_ARB_RR_EN
    test_rr();
`endif
    test_single();
`ifndef DMEM_ARB_RR_EN
    test_starvation();
    test_burst3();
`endif
    test_burst_cap();
    test_reset_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
